result_monitor: RTL and testbench
=================================

RESULT_MONITOR -- requirements
Module: result_monitor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand/result width; only 32 is supported.
REQ-002 The block SHALL have parameter OP, default 0, selecting the reference operation: 0 = a+b mod 2^WIDTH, 1 = a-b mod 2^WIDTH, 2 = low WIDTH bits of a*b.
REQ-003 The block SHALL have parameter DEPTH, default 16, giving the expected-result pipeline depth; the maximum supported latency is DEPTH-1.
REQ-004 The block SHALL have parameter NUM_CHECKS, default 1024, giving the number of comparisons per run.
REQ-005 The block SHALL have these ports, one per line:
- clk_dut  in  1  clock
- reset  in  1  asynchronous, active-high
- i_a  in  WIDTH  operand A as actually driven to the DUT, same cycle
- i_b  in  WIDTH  operand B as actually driven to the DUT, same cycle
- i_dut_out  in  WIDTH  DUT result
- i_dut_delay  in  32  measured DUT latency; 32'hFFFF = not yet measured
- o_state  out  2  FSM state
- o_done  out  1  run complete
- o_pass  out  1  o_done and zero errors
- o_check_count  out  32  comparisons performed
- o_err_count  out  32  mismatches
- o_first_exp  out  WIDTH  expected value at first mismatch
- o_first_got  out  WIDTH  DUT value at first mismatch

Function
REQ-006 Every cycle, the block SHALL compute exp = OP(i_a, i_b) and shift {valid=1, exp} into stage 0 of a DEPTH-entry pipeline; stage k holds the result for operands presented k+1 cycles earlier.
REQ-007 The FSM SHALL have states IDLE=0, FILL=1, CHECK=2 and DONE=3, and o_state SHALL equal the current state.
REQ-008 In IDLE, the block SHALL stay in IDLE while i_dut_delay==32'hFFFF.
REQ-009 On leaving IDLE, the block SHALL latch L = i_dut_delay[3:0]; if i_dut_delay==0 or i_dut_delay>=DEPTH, it SHALL go to DONE with o_pass=0 and o_err_count=32'hFFFFFFFF (bad latency); otherwise it SHALL go to FILL.
REQ-010 FILL SHALL last exactly L cycles, so that the selected tap holds valid data, and then go to CHECK.
REQ-011 In CHECK, each cycle the block SHALL compare i_dut_out with pipeline stage L-1 and increment o_check_count.
REQ-012 On mismatch, the block SHALL increment o_err_count; on the first mismatch only, it SHALL capture o_first_exp and o_first_got.
REQ-013 When o_check_count reaches NUM_CHECKS, the block SHALL go to DONE on the same clock edge as the last increment.
REQ-014 DONE SHALL be terminal until reset; o_done=1 and o_pass=(o_err_count==0).
REQ-015 Changes on i_dut_delay after L is latched SHALL be ignored.
REQ-016 Both counters SHALL saturate at 32'hFFFFFFFF.
REQ-017 A comparison SHALL NOT occur when the selected tap's valid bit is 0, and such a cycle SHALL NOT be counted.
REQ-018 Zero-operand cycles injected upstream SHALL be checked like any other cycle (exp = OP(0,0)).

Reset
REQ-019 On reset assertion, the block SHALL go to IDLE immediately and clear all pipeline valid bits, L, all counters, o_first_exp and o_first_got.
REQ-020 After reset, o_done=0, o_pass=0 and o_state=0.
REQ-021 Reset mid-CHECK SHALL abort the run with no residual counts; the next run restarts from IDLE.

Structure
REQ-022 Op codes, state encodings, the 32'hFFFF "unmeasured" sentinel and the saturation constant SHALL live in the shared package tb_pkg.
REQ-023 The expected-value pipeline SHALL be a sub-module exp_pipe (parameters WIDTH and DEPTH; inputs data and valid; a tap-select input; tap data and tap valid out).

Verification
REQ-024 OP=0, model DUT = registered adder with L=3, i_dut_delay=3 after 20 cycles -> FILL lasts 3 cycles, then after 1024 checks o_done=1, o_pass=1, o_err_count=0.
REQ-025 Same setup, with DUT output bit 0 flipped on check #100 -> o_err_count=1, o_first_got = o_first_exp ^ 1, o_pass=0.
REQ-026 i_dut_delay=16 with DEPTH=16 -> DONE on the next cycle, o_err_count=32'hFFFFFFFF, o_pass=0.
REQ-027 Correct adder with L=3 but i_dut_delay=4 -> nearly every check fails; o_err_count>1000.
REQ-028 Reset pulsed at check #500, then a clean rerun -> o_check_count=1024 and o_err_count=0 at DONE.
REQ-029 OP=2 with a=32'hFFFFFFFF, b=2 -> exp=32'hFFFFFFFE, checked with no mismatch.

Source files
------------

// File: rtl/tb_pkg.sv
// Shared definitions for the result monitor: operation codes, FSM state
// encoding, the "latency not yet measured" sentinel, the counter saturation
// value and the reference-operation helper.
package tb_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } mon_state_e;

  localparam logic [31:0] DELAY_UNMEASURED = 32'h0000_FFFF;
  localparam logic [31:0] SAT_MAX          = 32'hFFFF_FFFF;

  // Reference result; only 32-bit operands are supported.
  function automatic logic [31:0] calc_exp(input int op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    case (op)
      1:       r = a - b;
      2:       r = a * b;
      default: r = a + b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/result_monitor_exp_pipe.sv
// exp_pipe: DEPTH-entry shift pipeline of expected results with per-stage
// valid bits. Stage k holds the value shifted in k+1 cycles earlier.
// Ports:
//   clk_dut, reset     clock, async active-high reset (clears valid bits)
//   i_data, i_valid    value shifted into stage 0 every cycle
//   i_tap_sel          stage index to observe
//   o_tap_data/valid   contents of the selected stage
module exp_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int SW = $clog2(DEPTH)
) (
  input  logic             clk_dut,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  input  logic [SW-1:0]    i_tap_sel,
  output logic [WIDTH-1:0] o_tap_data,
  output logic             o_tap_valid
);

  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]            vld_q, vld_d;

  always_comb begin
    data_d = {data_q[DEPTH-2:0], i_data};
    vld_d  = {vld_q[DEPTH-2:0], i_valid};
  end

  always_ff @(posedge clk_dut or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      vld_q  <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign o_tap_data  = data_q[i_tap_sel];
  assign o_tap_valid = vld_q[i_tap_sel];

endmodule

// File: rtl/result_monitor.sv
// result_monitor: checks a DUT's outputs against a reference operation
// delayed by the DUT's measured latency.
// Ports:
//   clk_dut, reset          clock, async active-high reset
//   i_a, i_b                operands as driven to the DUT this cycle
//   i_dut_out               DUT result
//   i_dut_delay             measured DUT latency (32'hFFFF = unmeasured)
//   o_state                 FSM state (IDLE/FILL/CHECK/DONE)
//   o_done, o_pass          run complete / complete with zero errors
//   o_check_count           comparisons performed (saturating)
//   o_err_count             mismatches (saturating; all-ones = bad latency)
//   o_first_exp/o_first_got values captured at the first mismatch
module result_monitor
  import tb_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int OP         = 0,
  parameter int DEPTH      = 16,
  parameter int NUM_CHECKS = 1024,
  localparam int SW = $clog2(DEPTH)
) (
  input  logic             clk_dut,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_dut_out,
  input  logic [31:0]      i_dut_delay,
  output logic [1:0]       o_state,
  output logic             o_done,
  output logic             o_pass,
  output logic [31:0]      o_check_count,
  output logic [31:0]      o_err_count,
  output logic [WIDTH-1:0] o_first_exp,
  output logic [WIDTH-1:0] o_first_got
);

  mon_state_e       state_q, state_d;
  logic [SW-1:0]    lat_q, lat_d;
  logic [SW-1:0]    fill_q, fill_d;
  logic [31:0]      chk_q, chk_d;
  logic [31:0]      err_q, err_d;
  logic [WIDTH-1:0] fexp_q, fexp_d;
  logic [WIDTH-1:0] fgot_q, fgot_d;

  logic [WIDTH-1:0] exp_now;
  logic [WIDTH-1:0] tap_data;
  logic             tap_vld;

  assign exp_now = WIDTH'(calc_exp(OP, 32'(i_a), 32'(i_b)));

  // Latency L lines up with stage L-1; in IDLE the tap is unused.
  exp_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_pipe (
    .clk_dut    (clk_dut),
    .reset      (reset),
    .i_data     (exp_now),
    .i_valid    (1'b1),
    .i_tap_sel  (lat_q - SW'(1)),
    .o_tap_data (tap_data),
    .o_tap_valid(tap_vld)
  );

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    fill_d  = fill_q;
    chk_d   = chk_q;
    err_d   = err_q;
    fexp_d  = fexp_q;
    fgot_d  = fgot_q;
    case (state_q)
      ST_IDLE: begin
        if (i_dut_delay != DELAY_UNMEASURED) begin
          lat_d = i_dut_delay[SW-1:0];
          if (i_dut_delay == '0 || i_dut_delay >= 32'(DEPTH)) begin
            state_d = ST_DONE;
            err_d   = SAT_MAX;
          end else begin
            state_d = ST_FILL;
            fill_d  = i_dut_delay[SW-1:0];
          end
        end
      end
      ST_FILL: begin
        if (fill_q == SW'(1)) state_d = ST_CHECK;
        else                  fill_d  = fill_q - SW'(1);
      end
      ST_CHECK: begin
        if (tap_vld) begin
          if (chk_q != SAT_MAX) chk_d = chk_q + 32'd1;
          if (i_dut_out != tap_data) begin
            if (err_q != SAT_MAX) err_d = err_q + 32'd1;
            if (err_q == '0) begin
              fexp_d = tap_data;
              fgot_d = i_dut_out;
            end
          end
          if (chk_d == 32'(NUM_CHECKS)) state_d = ST_DONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_dut or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
      fill_q  <= '0;
      chk_q   <= '0;
      err_q   <= '0;
      fexp_q  <= '0;
      fgot_q  <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      fill_q  <= fill_d;
      chk_q   <= chk_d;
      err_q   <= err_d;
      fexp_q  <= fexp_d;
      fgot_q  <= fgot_d;
    end
  end

  assign o_state       = state_q;
  assign o_done        = (state_q == ST_DONE);
  assign o_pass        = (state_q == ST_DONE) && (err_q == '0);
  assign o_check_count = chk_q;
  assign o_err_count   = err_q;
  assign o_first_exp   = fexp_q;
  assign o_first_got   = fgot_q;

endmodule

// File: tb/tb_result_monitor.sv
// Bench for result_monitor: a modelled DUT (delay line of the reference
// operation) feeds the monitor; a scoreboard recomputes what the monitor
// should report from the cycle timeline and the operand history.
module tb_result_monitor;

  localparam int T0 = 20;   // cycle whose closing edge leaves IDLE
  localparam int NCHK = 1024;
  localparam int NCHK_MUL = 64;

  logic        clk_dut = 1'b0;
  logic        reset;
  logic [31:0] i_a, i_b, dut_out, mul_out, i_dut_delay, mul_delay;

  logic [1:0]  st, st_m;
  logic        done, pass, done_m, pass_m;
  logic [31:0] cnt, err, fexp, fgot, cnt_m, err_m, fexp_m, fgot_m;

  logic [31:0] ha [0:1199];
  logic [31:0] hb [0:1199];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_dut = ~clk_dut;

  result_monitor #(.WIDTH(32), .OP(0), .DEPTH(16), .NUM_CHECKS(NCHK)) u_dut (
    .clk_dut(clk_dut), .reset(reset), .i_a(i_a), .i_b(i_b),
    .i_dut_out(dut_out), .i_dut_delay(i_dut_delay),
    .o_state(st), .o_done(done), .o_pass(pass),
    .o_check_count(cnt), .o_err_count(err),
    .o_first_exp(fexp), .o_first_got(fgot)
  );

  result_monitor #(.WIDTH(32), .OP(2), .DEPTH(16), .NUM_CHECKS(NCHK_MUL)) u_dut_mul (
    .clk_dut(clk_dut), .reset(reset), .i_a(i_a), .i_b(i_b),
    .i_dut_out(mul_out), .i_dut_delay(mul_delay),
    .o_state(st_m), .o_done(done_m), .o_pass(pass_m),
    .o_check_count(cnt_m), .o_err_count(err_m),
    .o_first_exp(fexp_m), .o_first_got(fgot_m)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input int op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      1:       return a + (~b + 32'd1);
      2:       return p[31:0];
      default: return a + b;
    endcase
  endfunction

  // Drive operands and modelled DUT outputs for cycle c.
  task automatic drive(input int c, input int dlat, input int flip_cyc);
    i_a = $urandom;
    i_b = $urandom;
    if (c == 25) begin i_a = 32'hFFFF_FFFF; i_b = 32'd2; end
    if (c == 30) begin i_a = '0; i_b = '0; end
    ha[c] = i_a;
    hb[c] = i_b;
    dut_out = (c >= dlat) ? ref_op(0, ha[c-dlat], hb[c-dlat]) : 32'd0;
    if (c == flip_cyc) dut_out = dut_out ^ 32'd1;
    mul_out = (c >= 1) ? ref_op(2, ha[c-1], hb[c-1]) : 32'd0;
    if (c == 26) mul_out = 32'hFFFF_FFFE;
  endtask

  // One run: DUT latency dlat, reported latency dval, bit-0 flip on check
  // flip_k, reset pulsed during check abort_k (0 = none).
  task automatic run(input int dlat, input int dval, input int flip_k,
                     input int abort_k, input bit chk_mul);
    int          l, k, end_cyc, flip_cyc, errs;
    bit          bad;
    logic [31:0] e, first_e, first_g;
    l   = dval & 15;
    bad = (dval == 0) || (dval >= 16);
    end_cyc  = bad ? T0 : T0 + l + NCHK;
    flip_cyc = (flip_k > 0) ? T0 + l + flip_k - 1 : -1;
    errs = 0; first_e = '0; first_g = '0;

    reset = 1'b1;
    i_dut_delay = 32'h0000_FFFF;
    mul_delay   = 32'h0000_FFFF;
    repeat (2) @(posedge clk_dut);
    #1 reset = 1'b0;
    drive(0, dlat, flip_cyc);
    chk("rst_state", {30'd0, st}, 32'd0);
    chk("rst_done_pass", {30'd0, done, pass}, 32'd0);
    chk("rst_cnt", cnt, 32'd0);
    chk("rst_err", err, 32'd0);
    chk("rst_first", fexp | fgot, 32'd0);

    for (int c = 1; c <= end_cyc; c++) begin
      @(posedge clk_dut);
      #1;
      drive(c, dlat, flip_cyc);
      if (c == T0 - 1) begin i_dut_delay = dval; mul_delay = 32'd1; end
      if (c == T0 + 5) i_dut_delay = 32'd7;   // must be ignored once latched
      if (c == T0 - 1) chk("idle_wait", {30'd0, st}, 32'd0);
      if (c == T0) chk("leave_idle", {30'd0, st}, bad ? 32'd3 : 32'd1);
      if (!bad && c == T0 + l - 1) chk("fill_last", {30'd0, st}, 32'd1);
      if (!bad && c == T0 + l) chk("check_enter", {30'd0, st}, 32'd2);
      if (chk_mul && c == T0 + 1 + NCHK_MUL) begin
        chk("mul_done_pass", {30'd0, done_m, pass_m}, 32'd3);
        chk("mul_cnt", cnt_m, NCHK_MUL);
        chk("mul_err", err_m, 32'd0);
      end
      k = c - (T0 + l) + 1;
      if (!bad && k >= 1 && k <= NCHK) begin
        e = ref_op(0, ha[c-l], hb[c-l]);
        if (dut_out != e) begin
          if (errs == 0) begin first_e = e; first_g = dut_out; end
          errs++;
        end
        if (k == abort_k) begin
          #2 reset = 1'b1;
          #1;
          chk("abort_state", {30'd0, st}, 32'd0);
          chk("abort_cnt", cnt, 32'd0);
          chk("abort_err", err, 32'd0);
          return;
        end
      end
    end

    chk("end_state", {30'd0, st}, 32'd3);
    chk("end_done_pass", {30'd0, done, pass}, {30'd0, 1'b1, !bad && errs == 0});
    chk("end_cnt", cnt, bad ? 32'd0 : NCHK);
    chk("end_err", err, bad ? 32'hFFFF_FFFF : errs);
    if (!bad && errs > 0) begin
      chk("first_exp", fexp, first_e);
      chk("first_got", fgot, first_g);
    end
    for (int c = end_cyc + 1; c <= end_cyc + 3; c++) begin
      @(posedge clk_dut);
      #1 drive(c, dlat, -1);
    end
    chk("done_hold", {30'd0, st}, 32'd3);
    chk("done_cnt_hold", cnt, bad ? 32'd0 : NCHK);
  endtask

  initial begin
    int r;
    reset = 1'b1;
    i_a = '0; i_b = '0; dut_out = '0; mul_out = '0;
    i_dut_delay = 32'h0000_FFFF; mul_delay = 32'h0000_FFFF;
    run(3, 3, 0, 0, 1'b1);     // clean adder run, plus multiply instance
    run(3, 3, 100, 0, 1'b0);   // single flipped bit on check #100
    run(3, 16, 0, 0, 1'b0);    // latency out of range
    run(3, 4, 0, 0, 1'b0);     // misreported latency
    run(3, 0, 0, 0, 1'b0);     // zero latency is invalid
    run(3, 3, 0, 500, 1'b0);   // abort mid-run
    run(3, 3, 0, 0, 1'b0);     // clean rerun after abort
    run(15, 15, 0, 0, 1'b0);   // maximum latency
    r = $urandom_range(1, 14);
    run(r, r, $urandom_range(1, NCHK), 0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
